// File: rtl/imem_icache_pkg.sv
// Shared types and constants for the instruction-fetch line cache.
// Fill FSM state encoding plus the line geometry used by the cache and its line array.
package imem_icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } icache_state_t;

  localparam int ICACHE_OFFSET_W = 5;
  localparam int ICACHE_BEAT_W   = 64;

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: valid/tag/data flops, combinational read by index.
// Whole-line write (tag, data, valid) in one cycle so no partial line is ever visible.
module icache_line_array
  import imem_icache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - ICACHE_OFFSET_W - IDX_W,
  parameter int LINE_W   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/imem_icache.sv
// Read-only direct-mapped I-cache: same-cycle hit response, 4-beat burst line fill on miss.
// Responds only in IDLE; a redirect during a fill lets the fill finish to the latched line.
module imem_icache
  import imem_icache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic        imem_resp,
  output logic [31:0] imem_rdata,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int IDX_W      = $clog2(NUM_SETS);
  localparam int TAG_W      = 32 - ICACHE_OFFSET_W - IDX_W;
  localparam int LINE_W     = LINE_BEATS * ICACHE_BEAT_W;
  localparam int BUF_W      = (LINE_BEATS - 1) * ICACHE_BEAT_W;
  localparam int BEAT_CNT_W = $clog2(LINE_BEATS);

  icache_state_t          state_q, state_d;
  logic [31:0]            line_addr_q, line_addr_d;
  logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
  logic [BUF_W-1:0]       buf_q, buf_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        req_word;
  logic              req_vld;
  logic              hit;
  logic              beat_ok;
  logic              last_beat;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en;
  logic              unused_addr_bits;

  assign req_idx   = imem_addr[ICACHE_OFFSET_W +: IDX_W];
  assign req_tag   = imem_addr[31 -: TAG_W];
  assign req_word  = imem_addr[4:2];
  assign req_vld   = |imem_rmask;
  assign hit       = req_vld && rd_valid && (rd_tag == req_tag);
  assign beat_ok   = bmem_rvalid && (bmem_raddr == line_addr_q);
  assign last_beat = (beat_q == BEAT_CNT_W'(LINE_BEATS - 1));

  assign unused_addr_bits = ^imem_addr[1:0];

  assign bmem_read = (state_q == REQ);
  assign bmem_addr = line_addr_q;

  icache_line_array #(
    .NUM_SETS(NUM_SETS),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (req_idx),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (line_addr_q[ICACHE_OFFSET_W +: IDX_W]),
    .wr_tag_i  (line_addr_q[31 -: TAG_W]),
    .wr_data_i ({bmem_rdata, buf_q})
  );

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    imem_resp   = 1'b0;
    imem_rdata  = '0;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          imem_resp  = 1'b1;
          imem_rdata = rd_data[{req_word, 5'b0} +: 32];
        end else if (req_vld) begin
          line_addr_d = {imem_addr[31:ICACHE_OFFSET_W], {ICACHE_OFFSET_W{1'b0}}};
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bmem_ready) begin
          state_d = FILL;
          beat_d  = '0;
        end
      end
      FILL: begin
        // Earlier beats shift down so beat 0 ends at the bottom of the line.
        if (beat_ok) begin
          if (last_beat) begin
            wr_en   = 1'b1;
            state_d = IDLE;
          end else begin
            buf_d  = {bmem_rdata, buf_q[BUF_W-1:ICACHE_BEAT_W]};
            beat_d = beat_q + BEAT_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      imem_resp  = 1'b0;
      imem_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      beat_q      <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
